// File: rtl/sort_session_ctrl.sv
// Session sequencer around the bubble-sort engine: loads N words into the RAM,
// hands the RAM to the sorter, waits for it to finish, then streams the words out.
module sort_session_ctrl #(
    parameter int N      = 8,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              ss_clk,
    input  logic              ss_rst_n,
    input  logic              ss_start,
    input  logic              ss_abort,
    input  logic              ss_in_valid,
    input  logic [DATA_W-1:0] ss_in_data,
    output logic              ss_in_ready,
    output logic              ss_out_valid,
    output logic [DATA_W-1:0] ss_out_data,
    input  logic              ss_out_ready,
    output logic [ADDR_W-1:0] ss_mem_addr,
    output logic [DATA_W-1:0] ss_mem_wdata,
    output logic              ss_mem_we,
    output logic              ss_mem_re,
    input  logic [DATA_W-1:0] ss_mem_rdata,
    output logic              ss_mem_own,
    output logic              ss_sort_go,
    input  logic              ss_sort_done,
    output logic              ss_busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_GO, S_SORT, S_RELEASE, S_RD, S_HOLD
    } state_t;

    localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(N - 1);

    state_t              r_state, w_next;
    logic [ADDR_W:0]     r_k, w_k_next;
    logic                r_out_valid, w_out_valid_next;
    logic [DATA_W-1:0]   r_out_data, w_out_data_next;

    always_ff @(posedge ss_clk) begin
        if (!ss_rst_n) begin
            r_state     <= S_IDLE;
            r_k         <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            r_state     <= w_next;
            r_k         <= w_k_next;
            r_out_valid <= w_out_valid_next;
            r_out_data  <= w_out_data_next;
        end
    end

    always_comb begin
        w_next           = r_state;
        w_k_next         = r_k;
        w_out_valid_next = r_out_valid;
        w_out_data_next  = r_out_data;
        ss_in_ready      = 1'b0;
        ss_mem_addr      = '0;
        ss_mem_wdata     = '0;
        ss_mem_we        = 1'b0;
        ss_mem_re        = 1'b0;
        ss_mem_own       = 1'b0;
        ss_sort_go       = 1'b0;
        case (r_state)
            S_IDLE: if (ss_start) begin
                w_next   = S_LOAD;
                w_k_next = '0;
            end
            S_LOAD: begin
                ss_in_ready = 1'b1;
                if (ss_in_valid) begin
                    ss_mem_we    = 1'b1;
                    ss_mem_addr  = r_k[ADDR_W-1:0];
                    ss_mem_wdata = ss_in_data;
                    w_k_next     = r_k + 1'b1;
                    if (r_k == LAST) w_next = S_GO;
                end
            end
            S_GO: begin
                ss_mem_own = 1'b1;
                ss_sort_go = 1'b1;
                w_next     = S_SORT;
            end
            S_SORT: begin
                ss_mem_own = 1'b1;
                if (ss_sort_done) w_next = S_RELEASE;
            end
            // Done must drop before readout so the sorter has left the RAM.
            S_RELEASE: begin
                ss_mem_own = 1'b1;
                if (!ss_sort_done) begin
                    w_next   = S_RD;
                    w_k_next = '0;
                end
            end
            S_RD: begin
                ss_mem_re   = 1'b1;
                ss_mem_addr = r_k[ADDR_W-1:0];
                w_next      = S_HOLD;
            end
            S_HOLD: begin
                if (!r_out_valid) begin
                    w_out_data_next  = ss_mem_rdata;
                    w_out_valid_next = 1'b1;
                end else if (ss_out_ready) begin
                    w_out_valid_next = 1'b0;
                    w_k_next         = r_k + 1'b1;
                    w_next           = (r_k == LAST) ? S_IDLE : S_RD;
                end
            end
            default: w_next = S_IDLE;
        endcase
        // Abort wins over everything and must not leave a write behind.
        if (ss_abort && r_state != S_IDLE) begin
            w_next           = S_IDLE;
            w_out_valid_next = 1'b0;
            ss_in_ready      = 1'b0;
            ss_mem_we        = 1'b0;
            ss_sort_go       = 1'b0;
        end
    end

    assign ss_out_valid = r_out_valid;
    assign ss_out_data  = r_out_data;
    assign ss_busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_sort_session_ctrl.sv
// Directed bench for sort_session_ctrl with a behavioural RAM and sorter model.
module tb_sort_session_ctrl;
    localparam int N = 8, DW = 8, AW = 4;

    logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
    logic          in_valid = 1'b0, out_ready = 1'b0, done = 1'b0, do_sort = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready, out_valid, we, re, own, sort_go, busy;
    logic [DW-1:0] out_data, wdata, rdata;
    logic [AW-1:0] addr;
    logic [15:0][7:0] mem;

    int n_chk = 0, n_err = 0, go_cnt = 0, bad = 0;

    sort_session_ctrl #(.N(N), .DATA_W(DW), .ADDR_W(AW)) dut (
        .ss_clk(clk), .ss_rst_n(rst_n), .ss_start(start), .ss_abort(abort),
        .ss_in_valid(in_valid), .ss_in_data(in_data), .ss_in_ready(in_ready),
        .ss_out_valid(out_valid), .ss_out_data(out_data), .ss_out_ready(out_ready),
        .ss_mem_addr(addr), .ss_mem_wdata(wdata), .ss_mem_we(we), .ss_mem_re(re),
        .ss_mem_rdata(rdata), .ss_mem_own(own), .ss_sort_go(sort_go),
        .ss_sort_done(done), .ss_busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0][7:0] sort8(input logic [15:0][7:0] m);
        logic [7:0] t;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N - 1 - i; j++)
                if (m[j] > m[j+1]) begin
                    t = m[j]; m[j] = m[j+1]; m[j+1] = t;
                end
        return m;
    endfunction

    always @(posedge clk) begin
        if (do_sort) mem <= sort8(mem);
        else if (we && !own) mem[addr] <= wdata;
        if (re && !own) rdata <= mem[addr];
    end

    // Sorter model: sorts a few cycles after go, holds done for 3 cycles.
    initial forever begin
        @(negedge clk);
        if (sort_go) begin
            repeat (5) @(negedge clk);
            do_sort = 1'b1;
            @(negedge clk);
            do_sort = 1'b0;
            done = 1'b1;
            repeat (3) @(negedge clk);
            done = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (sort_go) go_cnt <= go_cnt + 1;
        if (own && (we || re)) bad <= bad + 1;
        if (sort_go && !own) bad <= bad + 1;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", tag, act, exp);
        end
    endtask

    task automatic begin_session();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_start", busy, 1);
    endtask

    task automatic load(input logic [7:0] d[8], input bit gapped, input int n_words);
        int i = 0, c = 0;
        logic acc;
        while (i < n_words && c < 200) begin
            in_valid = gapped ? (c % 2 == 0) : 1'b1;
            in_data  = d[i];
            acc = in_valid && in_ready;
            @(negedge clk);
            if (acc) i++;
            c++;
        end
        in_valid = 1'b0;
        chk("load_cnt", i, n_words);
    endtask

    task automatic unload(input logic [7:0] e[8], input bit toggle, input bit poke);
        int got = 0, c = 0;
        logic stall = 1'b0;
        logic [7:0] pd = '0;
        while (got < N && c < 400) begin
            if (stall) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_data", out_data, pd);
            end
            out_ready = toggle ? (c % 4 == 0 || c % 4 == 3) : 1'b1;
            start = poke && out_valid && got == 2;
            stall = out_valid && !out_ready;
            pd = out_data;
            if (out_valid && out_ready) begin
                chk("out_word", out_data, e[got]);
                got++;
            end
            @(negedge clk);
            c++;
        end
        out_ready = 1'b0;
        start = 1'b0;
        chk("out_cnt", got, N);
        chk("busy_end", busy, 0);
    endtask

    logic [7:0] d1[8] = '{5, 3, 7, 1, 8, 2, 6, 4};
    logic [7:0] e1[8] = '{1, 2, 3, 4, 5, 6, 7, 8};
    logic [7:0] d2[8] = '{4, 4, 0, 255, 0, 4, 255, 1};
    logic [7:0] e2[8] = '{0, 0, 1, 4, 4, 4, 255, 255};
    logic [7:0] d3[8] = '{9, 20, 15, 11, 30, 2, 17, 6};
    logic [7:0] e3[8] = '{2, 6, 9, 11, 15, 17, 20, 30};

    initial begin
        int g0, acc_seen;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_own", own, 0);
        chk("rst_go", sort_go, 0);
        chk("rst_we_re", {we, re}, 0);
        rst_n = 1'b1;

        // Back-to-back load, free-running output
        g0 = go_cnt;
        begin_session();
        load(d1, 1'b0, 8);
        chk("go_pulse", sort_go, 1);
        chk("own_at_go", own, 1);
        unload(e1, 1'b0, 1'b0);
        chk("go_cnt1", go_cnt - g0, 1);

        // Gapped input, toggling ready
        begin_session();
        load(d1, 1'b1, 8);
        unload(e1, 1'b1, 1'b0);

        // Duplicates and extremes
        begin_session();
        load(d2, 1'b0, 8);
        unload(e2, 1'b0, 1'b0);

        // Abort during SORT
        begin_session();
        load(d1, 1'b0, 8);
        repeat (2) @(negedge clk);
        chk("own_in_sort", own, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_own", own, 0);
        acc_seen = 0;
        repeat (15) begin
            if (re || out_valid) acc_seen++;
            @(negedge clk);
        end
        chk("abort_no_rd", acc_seen, 0);
        begin_session();
        load(d3, 1'b0, 8);
        unload(e3, 1'b0, 1'b0);

        // Reset mid-load after three words
        begin_session();
        load(d1, 1'b0, 3);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst2_busy", busy, 0);
        chk("rst2_out_data", out_data, 0);
        chk("rst2_own", own, 0);
        in_valid = 1'b1;
        in_data = 8'd77;
        acc_seen = 0;
        repeat (3) begin
            if (in_ready || we) acc_seen++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("rst2_no_accept", acc_seen, 0);
        begin_session();
        load(d2, 1'b0, 8);
        unload(e2, 1'b0, 1'b0);

        // in_valid during SORT and start during HOLD are ignored
        g0 = go_cnt;
        begin_session();
        load(d3, 1'b0, 8);
        @(negedge clk);
        in_valid = 1'b1;
        in_data = 8'd99;
        acc_seen = 0;
        repeat (3) begin
            if (in_ready || we) acc_seen++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("sort_no_accept", acc_seen, 0);
        unload(e3, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        chk("start_ignored", busy, 0);
        chk("go_cnt6", go_cnt - g0, 1);

        chk("own_conflict", bad, 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/sort_session_ctrl.md
# sort_session_ctrl

Session-level sequencer wrapped around the bubble-sort engine and its single-port data memory. It takes a block of N words from an upstream valid/ready stream into memory, hands memory ownership to the sort controller and pulses its go, waits for completion, then streams the sorted words out over a second valid/ready port. It owns the memory-port mux select, so the host side and the sorter never drive the RAM in the same cycle.

## Interface
- N, 8, words per session (2..2^ADDR_W)
- DATA_W, 8, word width
- ADDR_W, 4, memory address width
- ss_clk  in  1  clock, all state updates on rising edge
- ss_rst_n  in  1  reset, synchronous, active-low
- ss_start  in  1  begin a session (sampled only in IDLE)
- ss_abort  in  1  return to IDLE from any state
- ss_in_valid  in  1  input word valid
- ss_in_data  in  DATA_W  input word
- ss_in_ready  out  1  block accepts input word
- ss_out_valid  out  1  sorted word valid
- ss_out_data  out  DATA_W  sorted word (registered)
- ss_out_ready  in  1  downstream accepts word
- ss_mem_addr  out  ADDR_W  host-side RAM address
- ss_mem_wdata  out  DATA_W  host-side RAM write data
- ss_mem_we  out  1  host-side RAM write enable
- ss_mem_re  out  1  host-side RAM read enable
- ss_mem_rdata  in  DATA_W  RAM read data, valid one cycle after ss_mem_re
- ss_mem_own  out  1  RAM mux select: 0 host side (this block), 1 sort controller
- ss_sort_go  out  1  go to sort controller, one-cycle pulse
- ss_sort_done  in  1  done from sort controller (level)
- ss_busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, LOAD, GO, SORT, RELEASE, RD, HOLD.
- Address counter k, width ADDR_W+1; cleared on entry to LOAD and RD-phase start.
- IDLE: all outputs low. ss_start=1 -> LOAD, k=0.
- LOAD: ss_in_ready=1. On ss_in_valid&ss_in_ready: ss_mem_we=1, ss_mem_addr=k[ADDR_W-1:0], ss_mem_wdata=ss_in_data (combinational from handshake), k++. When accepting word k=N-1 -> GO.
- GO: ss_mem_own=1, ss_sort_go=1 for exactly this cycle -> SORT.
- SORT: ss_mem_own=1; wait for ss_sort_done=1 -> RELEASE.
- RELEASE: ss_mem_own=1; wait for ss_sort_done=0 (sorter back in its wait state, its readout loop finished) -> RD, k=0, ss_mem_own=0 on the same edge.
- RD: ss_mem_re=1, ss_mem_addr=k -> HOLD.
- HOLD: ss_out_data captured from ss_mem_rdata on entry edge+0 (first HOLD cycle loads the register); ss_out_valid=1 from the following cycle until ss_out_ready=1. On handshake: k++; if k was N-1 -> IDLE, else -> RD.
- ss_out_data and ss_out_valid stable while ss_out_valid=1 and ss_out_ready=0.
- ss_abort=1 in any non-IDLE state -> IDLE next edge; no write in that cycle (abort masks ss_mem_we, ss_in_ready, ss_sort_go). Abort has priority over start, handshakes and done.
- ss_start while busy: ignored. ss_in_valid outside LOAD: ignored, ss_in_ready=0.
- ss_mem_own must be 0 whenever ss_mem_we or ss_mem_re is 1.

## Timing
- Reset (ss_rst_n=0 at an edge): state=IDLE, k=0, ss_out_data=0; all outputs 0 including ss_mem_own. Reset mid-session abandons it; sorter is released (own=0) next edge.
- Load: one word per cycle at full throughput, N cycles minimum.
- GO to sorter: 1 cycle after final load accept edge.
- Unload: 3 cycles per word minimum (RD, HOLD capture, HOLD valid), stalls indefinitely on ss_out_ready=0.
- Start-to-first-output latency: N + 1 + sort time + release time + 2 cycles.
- ss_sort_done already high on entry to SORT: still wait through RELEASE for it to fall; never issue a second go per session.

## Test plan
- N=8, load 5,3,7,1,8,2,6,4 back-to-back with sorter model -> one go pulse, own high GO..RELEASE, outputs 1,2,3,4,5,6,7,8 in order, ss_busy falls after 8th handshake.
- Gapped ss_in_valid (every other cycle) and ss_out_ready toggling 1,0,0,1 -> same sorted output, out_data held stable during stalls, no duplicated or dropped word.
- Duplicates 4,4,0,255,0,4,255,1 -> output 0,0,1,4,4,4,255,255.
- ss_abort during SORT -> IDLE next edge, own=0, no RD; subsequent ss_start runs a clean session.
- ss_rst_n=0 for one cycle mid-LOAD (k=3) -> all outputs 0, k=0; ss_in_valid afterwards not accepted until ss_start.
- ss_start asserted during HOLD and ss_in_valid during SORT -> both ignored, no memory write, session completes normally.
